// File: rtl/safe_pkg.sv
// Shared definitions for the safe combination lock.
//   state_t    : lock state encoding (ENTER, OPEN, LOCKOUT)
//   DEF_*      : default dial size, digit width, digit count and code
//   code_digit : extracts digit i from a packed code, where digit 0 is in the LSBs
package safe_pkg;

  typedef enum logic [1:0] {
    ENTER   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  localparam int DEF_DIAL_MAX = 40;
  localparam int DEF_DW       = 6;
  localparam int DEF_NDIG     = 3;
  // Digit 0 (entered first) is 12, then 30, then 5.
  localparam logic [DEF_NDIG*DEF_DW-1:0] DEF_CODE = {6'd5, 6'd30, 6'd12};

  // The helper works on a wide container so it can serve any code size the
  // top might be built with. The caller narrows the result to its own DW.
  localparam int CODE_MAXW = 64;

  function automatic logic [CODE_MAXW-1:0] code_digit(
    input logic [CODE_MAXW-1:0] code,
    input int unsigned          dw,
    input int unsigned          i
  );
    logic [CODE_MAXW-1:0] mask;
    mask = (CODE_MAXW'(1) << dw) - CODE_MAXW'(1);
    return (code >> (dw * i)) & mask;
  endfunction

endpackage

// File: rtl/safe_dial_counter.sv
// Modulo-DIAL_MAX up/down dial position counter.
//   clk, rst : clock and asynchronous active-high reset (reset clears dial to 0)
//   cnten    : active-low step strobe, one cycle per detent
//   up       : step direction while cnten=0 (1 = +1, 0 = -1)
//   dial     : current position, in the range 0..DIAL_MAX-1
module safe_dial_counter #(
  parameter int DIAL_MAX = 40,
  parameter int DW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cnten,
  input  logic          up,
  output logic [DW-1:0] dial
);

  localparam logic [DW-1:0] TOP = DW'(DIAL_MAX - 1);

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples the pre-edge values of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dial <= '0;
    end else if (!cnten) begin
      if (up) begin
        dial <= (dial == TOP) ? '0 : dial + 1'b1;
      end else begin
        dial <= (dial == '0) ? TOP : dial - 1'b1;
      end
    end
  end

endmodule

// File: rtl/safe_combo_lock.sv
// Safe combination lock. It follows the dial position and captures a digit on
// each direction reversal. After NDIG digits it compares the captured sequence
// with CODE and either opens or reports a failure.
//   clk, rst   : clock and asynchronous active-high reset
//   cnten, up  : decoded step strobe (active low) and step direction
//   dirch      : one-cycle pulse that marks a rotation reversal (capture)
//   lock       : one-cycle pulse that re-locks from OPEN
//   dial       : dial position
//   digit_idx  : number of digits captured in the current attempt
//   entry_strb : one-cycle pulse after each capture
//   unlocked   : high while OPEN
//   err        : one-cycle pulse when an attempt fails
//   locked_out : high during lockout
// Optional feature: define SAFE_LOCKOUT_EN to enable the lockout. MAX_FAIL
// consecutive failures then lock the safe for LOCKOUT_CYC cycles. Without
// the macro, locked_out is tied to 0.
module safe_combo_lock
  import safe_pkg::*;
#(
  parameter int                   DIAL_MAX    = DEF_DIAL_MAX,
  parameter int                   DW          = DEF_DW,
  parameter int                   NDIG        = DEF_NDIG,
  parameter logic [NDIG*DW-1:0]   CODE        = DEF_CODE,
  parameter int                   MAX_FAIL    = 3,
  parameter int                   LOCKOUT_CYC = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cnten,
  input  logic                  up,
  input  logic                  dirch,
  input  logic                  lock,
  output logic [DW-1:0]         dial,
  output logic [$clog2(NDIG):0] digit_idx,
  output logic                  entry_strb,
  output logic                  unlocked,
  output logic                  err,
  output logic                  locked_out
);

  localparam int IW = $clog2(NDIG) + 1;
  localparam int FW = $clog2(MAX_FAIL + 1);

  state_t          state, state_nx;
  logic [IW-1:0]   idx_nx;
  logic            bad, bad_nx;
  logic [FW-1:0]   fail_cnt, fail_nx, fail_inc;
  logic            strb_nx, err_nx;
  logic [DW-1:0]   want;
  logic            hit;

  safe_dial_counter #(
    .DIAL_MAX (DIAL_MAX),
    .DW       (DW)
  ) u_dial (
    .clk   (clk),
    .rst   (rst),
    .cnten (cnten),
    .up    (up),
    .dial  (dial)
  );

  // The dial register still holds its pre-step value during the capture
  // cycle. A capture that coincides with a step therefore sees the old
  // position.
  assign want     = DW'(code_digit(CODE_MAXW'(CODE), DW, 32'(digit_idx)));
  assign hit      = (dial == want);
  assign fail_inc = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

`ifdef SAFE_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYC) + 1;
  logic [LW-1:0] lock_cnt, cnt_nx;
`endif

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves one unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    idx_nx   = digit_idx;
    bad_nx   = bad;
    fail_nx  = fail_cnt;
    strb_nx  = 1'b0;
    err_nx   = 1'b0;
`ifdef SAFE_LOCKOUT_EN
    cnt_nx   = lock_cnt;
`endif
    case (state)
      ENTER: begin
        if (dirch) begin
          strb_nx = 1'b1;
          if (digit_idx == IW'(NDIG - 1)) begin
            // The failure is judged only on the last digit. This way the
            // result never shows which digit was wrong.
            idx_nx = '0;
            bad_nx = 1'b0;
            if (!bad && hit) begin
              state_nx = OPEN;
              fail_nx  = '0;
            end else begin
              err_nx  = 1'b1;
              fail_nx = fail_inc;
`ifdef SAFE_LOCKOUT_EN
              if (fail_inc == FW'(MAX_FAIL)) begin
                state_nx = LOCKOUT;
                cnt_nx   = LW'(LOCKOUT_CYC - 1);
              end
`endif
            end
          end else begin
            idx_nx = digit_idx + 1'b1;
            if (!hit) bad_nx = 1'b1;
          end
        end
      end
      OPEN: begin
        idx_nx = '0;
        if (lock) state_nx = ENTER;
      end
      LOCKOUT: begin
`ifdef SAFE_LOCKOUT_EN
        if (lock_cnt == '0) begin
          state_nx = ENTER;
          fail_nx  = '0;
        end else begin
          cnt_nx = lock_cnt - 1'b1;
        end
`else
        state_nx = ENTER;
`endif
      end
      default: state_nx = ENTER;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ENTER;
      digit_idx  <= '0;
      bad        <= 1'b0;
      fail_cnt   <= '0;
      entry_strb <= 1'b0;
      err        <= 1'b0;
      unlocked   <= 1'b0;
    end else begin
      state      <= state_nx;
      digit_idx  <= idx_nx;
      bad        <= bad_nx;
      fail_cnt   <= fail_nx;
      entry_strb <= strb_nx;
      err        <= err_nx;
      unlocked   <= (state_nx == OPEN);
    end
  end

`ifdef SAFE_LOCKOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt   <= '0;
      locked_out <= 1'b0;
    end else begin
      lock_cnt   <= cnt_nx;
      locked_out <= (state_nx == LOCKOUT);
    end
  end
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_safe_combo_lock.sv
// Bench for safe_combo_lock. The bench keeps a rule-level model: the dial is
// an integer taken modulo 40, the current attempt is a queue of captured
// digits, and the lockout is a count of remaining cycles. A compare process
// checks every output against this model on each falling edge. Directed
// literal checks pin the key points of each scenario.
module tb_safe_combo_lock;

  localparam int DIAL_MAX    = 40;
  localparam int NDIG        = 3;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 100;

  logic       clk, rst;
  logic       cnten, up, dirch, lock;
  logic [5:0] dial;
  logic [2:0] digit_idx;
  logic       entry_strb, unlocked, err, locked_out;

  safe_combo_lock dut (
    .clk        (clk),
    .rst        (rst),
    .cnten      (cnten),
    .up         (up),
    .dirch      (dirch),
    .lock       (lock),
    .dial       (dial),
    .digit_idx  (digit_idx),
    .entry_strb (entry_strb),
    .unlocked   (unlocked),
    .err        (err),
    .locked_out (locked_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int code_q [NDIG] = '{12, 30, 5};
  int m_dial;
  int m_entry[$];
  bit m_open;
  int m_lock_left;
  int m_fails;
  bit m_strb, m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dial = 0; m_entry.delete(); m_open = 0; m_lock_left = 0;
      m_fails = 0; m_strb = 0; m_err = 0;
    end else begin
      bit match;
      m_strb = 0;
      m_err  = 0;
      if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) m_fails = 0;
      end else if (m_open) begin
        if (lock) m_open = 0;
      end else if (dirch) begin
        m_strb = 1;
        m_entry.push_back(m_dial);
        if (m_entry.size() == NDIG) begin
          match = 1;
          for (int k = 0; k < NDIG; k++) if (m_entry[k] != code_q[k]) match = 0;
          if (match) begin
            m_open  = 1;
            m_fails = 0;
          end else begin
            m_err = 1;
            m_fails++;
`ifdef SAFE_LOCKOUT_EN
            if (m_fails >= MAX_FAIL) m_lock_left = LOCKOUT_CYC;
`endif
          end
          m_entry.delete();
        end
      end
      if (!cnten) m_dial = (m_dial + (up ? 1 : DIAL_MAX - 1)) % DIAL_MAX;
    end
  end

  always @(negedge clk) begin
    check("dial", 32'(dial), m_dial);
    check("digit_idx", 32'(digit_idx), m_entry.size());
    check("entry_strb", 32'(entry_strb), 32'(m_strb));
    check("unlocked", 32'(unlocked), 32'(m_open));
    check("err", 32'(err), 32'(m_err));
    check("locked_out", 32'(locked_out), 32'(m_lock_left > 0));
  end

  // ---------------- stimulus ----------------
  // Applies one cycle of inputs from a falling edge and returns on the next
  // falling edge, when the outputs reflect that cycle.
  task automatic cyc(input bit c_n, input bit u, input bit d, input bit l);
    cnten = c_n; up = u; dirch = d; lock = l;
    @(negedge clk);
    cnten = 1'b1; dirch = 1'b0; lock = 1'b0;
  endtask

  task automatic goto_up(input int target);
    for (int k = 0; k < DIAL_MAX && m_dial != target; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic goto_dn(input int target);
    for (int k = 0; k < DIAL_MAX && m_dial != target; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_code;
    goto_up(12); cyc(1, 0, 1, 0);
    goto_up(30); cyc(1, 0, 1, 0);
    goto_dn(5);  cyc(1, 0, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cnten = 1'b1; up = 1'b0; dirch = 1'b0; lock = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dial", 32'(dial), 0);
    check("rst_idx", 32'(digit_idx), 0);
    check("rst_unlocked", 32'(unlocked), 0);
    rst = 1'b0;

    // Wrap in both directions.
    cyc(0, 0, 0, 0);
    check("wrap_down", 32'(dial), 39);
    cyc(0, 1, 0, 0);
    check("wrap_up", 32'(dial), 0);
    check("wrap_status", {entry_strb, unlocked, err, locked_out}, 0);

    // Correct code.
    goto_up(12);
    check("twelve_steps", 32'(dial), 12);
    cyc(1, 0, 1, 0);
    check("first_strb", 32'(entry_strb), 1);
    check("first_idx", 32'(digit_idx), 1);
    goto_up(30); cyc(1, 0, 1, 0);
    goto_dn(5);
    check("pre_open", 32'(unlocked), 0);
    cyc(1, 0, 1, 0);
    check("open", 32'(unlocked), 1);
    check("open_idx", 32'(digit_idx), 0);

    // Reversals in OPEN are ignored. Re-lock keeps the dial.
    cyc(1, 0, 1, 0);
    check("open_dirch_ignored", 32'(digit_idx), 0);
    cyc(1, 0, 0, 1);
    check("relock", 32'(unlocked), 0);
    check("relock_dial", 32'(dial), 5);
    cyc(1, 0, 0, 1);  // lock in ENTER has no effect

    // Wrong middle digit.
    goto_up(12); cyc(1, 0, 1, 0);
    goto_up(29); cyc(1, 0, 1, 0);
    check("wrong_no_early_err", 32'(err), 0);
    check("wrong_idx2", 32'(digit_idx), 2);
    goto_dn(5);  cyc(1, 0, 1, 0);
    check("wrong_err", 32'(err), 1);
    check("wrong_idx0", 32'(digit_idx), 0);
    check("wrong_locked", 32'(unlocked), 0);
    cyc(1, 0, 0, 0);
    check("err_one_cycle", 32'(err), 0);

    // Capture together with an up step at 12.
    goto_up(12);
    cyc(0, 1, 1, 0);
    check("sim_dial", 32'(dial), 13);
    check("sim_idx", 32'(digit_idx), 1);
    goto_up(30); cyc(1, 0, 1, 0);
    goto_dn(5);  cyc(1, 0, 1, 0);
    check("sim_reopen", 32'(unlocked), 1);
    cyc(1, 0, 0, 1);

    // Three wrong attempts at dial 5.
    repeat (3 * NDIG) cyc(1, 0, 1, 0);
    check("third_fail_err", 32'(err), 1);
`ifdef SAFE_LOCKOUT_EN
    begin
      int n = 0;
      while (locked_out === 1'b1 && n < 300) begin
        n++;
        cyc(0, 1, n[0], 0);
      end
      check("lockout_len", n, LOCKOUT_CYC);
    end
    enter_code();
    check("post_lockout_open", 32'(unlocked), 1);
    cyc(1, 0, 0, 1);
    repeat (3 * NDIG) cyc(1, 0, 1, 0);
    repeat (10) cyc(1, 0, 1, 0);
    check("mid_lockout", 32'(locked_out), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_lockout", 32'(locked_out), 0);
    check("async_rst_dial", 32'(dial), 0);
    @(negedge clk);
    rst = 1'b0;
`else
    check("no_lockout", 32'(locked_out), 0);
    enter_code();
    check("no_lockout_open", 32'(unlocked), 1);
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/safe_combo_lock.md
Name: safe_combo_lock

Overview:
- Downstream consumer of the rotary-encoder decoder FSM in the safe design.
- Turns decoded step/direction events into a modulo dial position.
- Captures a combination digit on every direction reversal and checks the captured sequence against a parameterised code.
- Drives the unlock indication and the error/status signals used by the display and bolt logic.

Parameters:
- DIAL_MAX, 40, number of dial positions; dial counts 0..DIAL_MAX-1.
- DW, 6, dial/digit width; must satisfy 2^DW >= DIAL_MAX.
- NDIG, 3, number of digits in the combination.
- CODE, {6'd5,6'd30,6'd12}, packed NDIG*DW code; digit 0 (first entered) in CODE[DW-1:0].
- MAX_FAIL, 3, consecutive failed attempts before lockout (feature-gated).
- LOCKOUT_CYC, 100, lockout duration in clk cycles (feature-gated).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cnten  in  1  active-low step strobe from decoder, one cycle per detent
- up  in  1  step direction, valid while cnten=0; 1=increment, 0=decrement
- dirch  in  1  one-cycle pulse, rotation direction reversed
- lock  in  1  synchronous pulse, re-lock from OPEN
- dial  out  DW  current dial position
- digit_idx  out  $clog2(NDIG)+1  digits captured in current attempt
- entry_strb  out  1  one-cycle pulse, digit captured
- unlocked  out  1  high in OPEN
- err  out  1  one-cycle pulse, attempt failed
- locked_out  out  1  high in LOCKOUT; tied 0 without feature

Behaviour:
- Reset: dial=0, digit_idx=0, entry_strb=0, unlocked=0, err=0, locked_out=0, state=ENTER, bad flag=0, fail_cnt=0. All outputs registered.
- Dial counting:
  - On a posedge with cnten=0: up=1 gives dial+1, up=0 gives dial-1.
  - Wrap: DIAL_MAX-1 +1 -> 0; 0 -1 -> DIAL_MAX-1.
  - Dial counts in every state, including OPEN and LOCKOUT.
- Capture:
  - On a posedge with dirch=1 in ENTER, the pre-step dial value is the captured digit.
  - If dirch and cnten=0 arrive together, capture the old value and still apply the step.
  - entry_strb pulses the following cycle.
- State ENTER (digit_idx = i):
  - On capture: mismatch with CODE digit i sets the bad flag. digit_idx increments.
  - When i = NDIG-1:
    - bad=0 and match -> OPEN, unlocked=1 one cycle after the dirch edge, fail_cnt=0.
    - Otherwise -> err pulse, digit_idx=0, bad=0, fail_cnt+1, remain ENTER.
  - Failure is reported only after NDIG entries, so it never reveals which digit was wrong.
- State OPEN:
  - dirch is ignored, digit_idx held at 0.
  - lock=1 -> ENTER, unlocked=0 next cycle.
  - lock in any other state has no effect.
- dial value is never reset by lock or by failure; only rst clears it.
- Reset mid-attempt: all state is cleared immediately (asynchronous).

Optional Feature:
- Macro: SAFE_LOCKOUT_EN.
- With the macro defined:
  - The failure that brings fail_cnt to MAX_FAIL enters LOCKOUT instead of staying in ENTER; err still pulses.
  - LOCKOUT: locked_out=1, dirch ignored, down-counter loaded with LOCKOUT_CYC-1.
  - When the counter reaches 0 -> ENTER, fail_cnt=0, locked_out=0.
- Without the macro: no lockout state or counter; locked_out tied 0; fail_cnt saturates and is unused.

Decomposition:
- Package safe_pkg holds:
  - the state encoding (ENTER, OPEN, LOCKOUT);
  - default DW, DIAL_MAX and CODE constants;
  - a digit-select function extracting CODE digit i.
- One sub-module: safe_dial_counter, the modulo-DIAL_MAX up/down counter driven by cnten/up, exposing dial.

Test Plan:
- Reset/wrap: assert rst, 1 down step -> dial=39; 1 up step -> dial=0; all status outputs 0.
- Correct code:
  - 12 up steps, dirch -> entry_strb, digit_idx=1.
  - Reach 30, dirch; reach 5, dirch -> unlocked=1 exactly one cycle after the third dirch.
- Wrong middle digit: enter 12, 29, 5 -> no err after the second entry; err pulse after the third; digit_idx=0, unlocked=0.
- Simultaneous dirch + up step at dial=12 -> captured digit 12, dial becomes 13.
- Re-lock: from OPEN, pulse lock -> unlocked=0; dial unchanged; a fresh correct sequence reopens.
- SAFE_LOCKOUT_EN:
  - 3 wrong attempts -> locked_out=1 for 100 cycles; dirch ignored during lockout.
  - After lockout, the correct code unlocks.
  - Reset asserted mid-lockout clears locked_out immediately.
